// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control pipeline: per-stage control field
// groups, their bubble values, and the instruction opcodes they are decoded from.
package ctrl_pkg;

  localparam int unsigned CTRL_REG_W = 5;
  localparam int unsigned CTRL_AOP_W = 3;

  typedef struct packed {
    logic                  reg_ds;
    logic [CTRL_AOP_W-1:0] aop;
    logic                  alu_src;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mread;
    logic mwrite;
  } m_ctrl_t;

  typedef struct packed {
    logic mtor;
    logic urw;
  } wb_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '0;
  localparam m_ctrl_t  M_BUBBLE  = '0;
  localparam wb_ctrl_t WB_BUBBLE = '0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-stage control bundle in, per-stage controls and hazard signals out.
// master = ID stage / environment, slave = ctrl_pipe.
interface ctrl_pipe_if
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_W = CTRL_REG_W,
  parameter int unsigned AOP_W = CTRL_AOP_W
);
  logic             id_valid;
  logic             id_RegDs;
  logic             id_Branch;
  logic             id_MRead;
  logic             id_MtoR;
  logic [AOP_W-1:0] id_AOp;
  logic             id_MWrite;
  logic             id_ALUsrc;
  logic             id_Urw;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             ex_zero;

  logic             ex_RegDs;
  logic             ex_ALUsrc;
  logic [AOP_W-1:0] ex_AOp;
  logic             mem_MRead;
  logic             mem_MWrite;
  logic             mem_pcsrc;
  logic             wb_MtoR;
  logic             wb_Urw;
  logic [REG_W-1:0] wb_wreg;
  logic             stall;
  logic             flush_ifid;

  modport master (
    output id_valid, id_RegDs, id_Branch, id_MRead, id_MtoR, id_AOp, id_MWrite,
           id_ALUsrc, id_Urw, id_rs, id_rt, id_rd, ex_zero,
    input  ex_RegDs, ex_ALUsrc, ex_AOp, mem_MRead, mem_MWrite, mem_pcsrc,
           wb_MtoR, wb_Urw, wb_wreg, stall, flush_ifid
  );

  modport slave (
    input  id_valid, id_RegDs, id_Branch, id_MRead, id_MtoR, id_AOp, id_MWrite,
           id_ALUsrc, id_Urw, id_rs, id_rt, id_rd, ex_zero,
    output ex_RegDs, ex_ALUsrc, ex_AOp, mem_MRead, mem_MWrite, mem_pcsrc,
           wb_MtoR, wb_Urw, wb_wreg, stall, flush_ifid
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use stall detection, branch resolution and stall/flush
// arbitration for the control pipeline.
module hazard_detect #(
  parameter int unsigned REG_W = 5
) (
  input  logic             ex_mread,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  output logic             pcsrc,
  output logic             flush,
  output logic             stall
);

  logic load_use;

  assign pcsrc = mem_branch & mem_zero;
  assign flush = pcsrc;

  // A load into r0 never creates a dependency.
  assign load_use = ex_mread & (ex_wreg != '0) & ((ex_wreg == id_rs) | (ex_wreg == id_rt))
                    & id_valid;

  // Younger instructions are being discarded on a flush, so holding them is pointless.
  assign stall = load_use & ~flush;

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoded controls and register fields through ID/EX, EX/MEM and MEM/WB,
// inserting bubbles on invalid issue, load-use stall and branch flush.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_W = CTRL_REG_W,
  parameter int unsigned AOP_W = CTRL_AOP_W
) (
  input logic        clk,
  input logic        rst_n,
  ctrl_pipe_if.slave bus
);

  typedef struct packed {
    ex_ctrl_t         ex;
    m_ctrl_t          m;
    wb_ctrl_t         wb;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    m_ctrl_t          m;
    wb_ctrl_t         wb;
    logic [REG_W-1:0] wreg;
    logic             zero;
  } exmem_t;

  typedef struct packed {
    wb_ctrl_t         wb;
    logic [REG_W-1:0] wreg;
  } memwb_t;

  idex_t  idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;

  logic [REG_W-1:0] ex_wreg;
  logic [AOP_W-1:0] id_aop;  // AOP_W is expected to equal CTRL_AOP_W
  logic             pcsrc;
  logic             flush;
  logic             stall;

  assign id_aop  = bus.id_AOp;
  assign ex_wreg = idex_q.ex.reg_ds ? idex_q.rd : idex_q.rt;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard (
    .ex_mread  (idex_q.m.mread),
    .ex_wreg   (ex_wreg),
    .id_valid  (bus.id_valid),
    .id_rs     (bus.id_rs),
    .id_rt     (bus.id_rt),
    .mem_branch(exmem_q.m.branch),
    .mem_zero  (exmem_q.zero),
    .pcsrc     (pcsrc),
    .flush     (flush),
    .stall     (stall)
  );

  // Controls are only sampled under id_valid so X on an idle ID stage cannot leak in.
  always_comb begin
    idex_d = '0;
    if (bus.id_valid && !stall && !flush) begin
      idex_d.ex.reg_ds  = bus.id_RegDs;
      idex_d.ex.aop     = id_aop;
      idex_d.ex.alu_src = bus.id_ALUsrc;
      idex_d.m.branch   = bus.id_Branch;
      idex_d.m.mread    = bus.id_MRead;
      idex_d.m.mwrite   = bus.id_MWrite;
      idex_d.wb.mtor    = bus.id_MtoR;
      idex_d.wb.urw     = bus.id_Urw;
      idex_d.rt         = bus.id_rt;
      idex_d.rd         = bus.id_rd;
    end
  end

  always_comb begin
    exmem_d = '0;
    if (!flush) begin
      exmem_d.m    = idex_q.m;
      exmem_d.wb   = idex_q.wb;
      exmem_d.wreg = ex_wreg;
      exmem_d.zero = bus.ex_zero;
    end
  end

  always_comb begin
    memwb_d      = '0;
    memwb_d.wb   = exmem_q.wb;
    memwb_d.wreg = exmem_q.wreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '{ex: EX_BUBBLE, m: M_BUBBLE, wb: WB_BUBBLE, rt: '0, rd: '0};
      exmem_q <= '{m: M_BUBBLE, wb: WB_BUBBLE, wreg: '0, zero: 1'b0};
      memwb_q <= '{wb: WB_BUBBLE, wreg: '0};
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign bus.ex_RegDs   = idex_q.ex.reg_ds;
  assign bus.ex_ALUsrc  = idex_q.ex.alu_src;
  assign bus.ex_AOp     = idex_q.ex.aop;
  assign bus.mem_MRead  = exmem_q.m.mread;
  assign bus.mem_MWrite = exmem_q.m.mwrite;
  assign bus.mem_pcsrc  = pcsrc;
  assign bus.wb_MtoR    = memwb_q.wb.mtor;
  assign bus.wb_Urw     = memwb_q.wb.urw;
  assign bus.wb_wreg    = memwb_q.wreg;
  assign bus.stall      = stall;
  assign bus.flush_ifid = flush;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: expected writebacks are queued at issue and
// matched as they leave MEM/WB; stage timing and hazards are checked directly.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  typedef struct packed {
    logic       valid;
    logic       regds;
    logic       branch;
    logic       mread;
    logic       mtor;
    logic [2:0] aop;
    logic       mwrite;
    logic       alusrc;
    logic       urw;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } id_t;

  typedef struct packed {
    logic       mtor;
    logic       urw;
    logic [4:0] wreg;
  } wb_exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  wb_exp_t sb[$];
  wb_exp_t mon_e;

  ctrl_pipe_if #(.REG_W(5), .AOP_W(3)) pif ();

  ctrl_pipe #(
    .REG_W(5),
    .AOP_W(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode of a MIPS-style opcode into the control bundle.
  function automatic id_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd);
    id_t v;
    v       = '0;
    v.valid = 1'b1;
    v.rs    = rs;
    v.rt    = rt;
    v.rd    = rd;
    case (op)
      OP_RTYPE: begin v.regds = 1'b1; v.aop = 3'b010; v.urw = 1'b1; end
      OP_LW:    begin v.alusrc = 1'b1; v.mread = 1'b1; v.mtor = 1'b1; v.urw = 1'b1; end
      OP_SW:    begin v.alusrc = 1'b1; v.mwrite = 1'b1; end
      OP_BEQ:   begin v.branch = 1'b1; v.aop = 3'b001; end
      OP_ADDI:  begin v.alusrc = 1'b1; v.urw = 1'b1; end
      default:  v.valid = 1'b0;
    endcase
    return v;
  endfunction

  function automatic id_t nop();
    id_t v;
    v       = 'x;
    v.valid = 1'b0;
    return v;
  endfunction

  function automatic wb_exp_t exp_of(input id_t v);
    wb_exp_t e;
    e.mtor = v.mtor;
    e.urw  = v.urw;
    e.wreg = v.regds ? v.rd : v.rt;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input id_t v, input logic zero);
    pif.id_valid  = v.valid;
    pif.id_RegDs  = v.regds;
    pif.id_Branch = v.branch;
    pif.id_MRead  = v.mread;
    pif.id_MtoR   = v.mtor;
    pif.id_AOp    = v.aop;
    pif.id_MWrite = v.mwrite;
    pif.id_ALUsrc = v.alusrc;
    pif.id_Urw    = v.urw;
    pif.id_rs     = v.rs;
    pif.id_rt     = v.rt;
    pif.id_rd     = v.rd;
    pif.ex_zero   = zero;
  endtask

  task automatic issue(input id_t v, input logic zero);
    @(negedge clk);
    drive(v, zero);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) issue(nop(), 1'b0);
  endtask

  function automatic logic [31:0] all_out();
    return 32'({pif.ex_RegDs, pif.ex_ALUsrc, pif.ex_AOp, pif.mem_MRead, pif.mem_MWrite,
                pif.mem_pcsrc, pif.wb_MtoR, pif.wb_Urw, pif.wb_wreg, pif.stall,
                pif.flush_ifid});
  endfunction

  function automatic logic [31:0] ex_out();
    return 32'({pif.ex_RegDs, pif.ex_ALUsrc, pif.ex_AOp});
  endfunction

  // Any non-bubble writeback must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (pif.wb_Urw || pif.wb_MtoR || pif.wb_wreg != '0)) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'({pif.wb_MtoR, pif.wb_Urw, pif.wb_wreg}), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_scoreboard", 32'({pif.wb_MtoR, pif.wb_Urw, pif.wb_wreg}), 32'(mon_e));
      end
    end
  end

  initial begin
    id_t r5, sw4, lw8, add8, lw0, add0, beq, y1, y2, lw8b, add8b, r13, r14, r15, r16;
    n_chk  = 0;
    n_pass = 0;

    rst_n = 1'b0;
    drive(nop(), 1'b0);
    #3;
    chk("reset_held", all_out(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release", all_out(), 0);

    // R-type latency
    r5 = mk(OP_RTYPE, 5'd1, 5'd2, 5'd5);
    issue(r5, 1'b0);
    chk("r_ex_before_edge", 32'(pif.ex_AOp), 0);
    sb.push_back(exp_of(r5));
    issue(nop(), 1'b0);
    chk("r_ex_aop", 32'(pif.ex_AOp), 2);
    chk("r_ex_regds", 32'(pif.ex_RegDs), 1);
    issue(nop(), 1'b0);
    chk("r_wb_not_yet", 32'(pif.wb_Urw), 0);
    issue(nop(), 1'b0);
    chk("r_wb_urw", 32'(pif.wb_Urw), 1);
    chk("r_wb_wreg", 32'(pif.wb_wreg), 5);

    // Store reaches MEM two edges after issue
    sw4 = mk(OP_SW, 5'd1, 5'd4, 5'd0);
    issue(sw4, 1'b0);
    sb.push_back(exp_of(sw4));
    issue(nop(), 1'b0);
    issue(nop(), 1'b0);
    chk("sw_mem_mwrite", 32'(pif.mem_MWrite), 1);
    drain(2);

    // Load-use stall
    lw8  = mk(OP_LW, 5'd1, 5'd8, 5'd0);
    add8 = mk(OP_RTYPE, 5'd8, 5'd3, 5'd9);
    issue(lw8, 1'b0);
    chk("lu_no_stall_first", 32'(pif.stall), 0);
    sb.push_back(exp_of(lw8));
    issue(add8, 1'b0);
    chk("lu_stall", 32'(pif.stall), 1);
    chk("lu_ex_is_load", 32'(pif.ex_ALUsrc), 1);
    issue(add8, 1'b0);
    chk("lu_stall_one_cycle", 32'(pif.stall), 0);
    chk("lu_ex_bubble", ex_out(), 0);
    chk("lu_mem_mread", 32'(pif.mem_MRead), 1);
    sb.push_back(exp_of(add8));
    issue(nop(), 1'b0);
    chk("lu_add_late_ex", ex_out(), 32'({1'b1, 1'b0, 3'b010}));
    drain(3);

    // Load to r0 never stalls
    lw0  = mk(OP_LW, 5'd1, 5'd0, 5'd0);
    add0 = mk(OP_RTYPE, 5'd0, 5'd3, 5'd10);
    issue(lw0, 1'b0);
    sb.push_back(exp_of(lw0));
    issue(add0, 1'b0);
    chk("r0_no_stall", 32'(pif.stall), 0);
    sb.push_back(exp_of(add0));
    issue(nop(), 1'b0);
    chk("r0_add_on_time", 32'(pif.ex_RegDs), 1);
    drain(3);

    // Taken branch flushes the two younger instructions
    beq = mk(OP_BEQ, 5'd1, 5'd2, 5'd0);
    y1  = mk(OP_RTYPE, 5'd3, 5'd4, 5'd11);
    y2  = mk(OP_RTYPE, 5'd3, 5'd4, 5'd12);
    issue(beq, 1'b0);
    sb.push_back(exp_of(beq));
    issue(y1, 1'b1);
    chk("br_no_flush_early", 32'(pif.flush_ifid), 0);
    issue(y2, 1'b0);
    chk("br_pcsrc", 32'(pif.mem_pcsrc), 1);
    chk("br_flush", 32'(pif.flush_ifid), 1);
    issue(nop(), 1'b0);
    chk("br_pcsrc_drop", 32'(pif.mem_pcsrc), 0);
    chk("br_ex_bubble", ex_out(), 0);
    chk("br_wb_urw", 32'(pif.wb_Urw), 0);
    chk("br_wb_wreg", 32'(pif.wb_wreg), 2);
    drain(3);

    // Stall and flush together: flush wins
    lw8b  = mk(OP_LW, 5'd1, 5'd8, 5'd0);
    add8b = mk(OP_RTYPE, 5'd8, 5'd3, 5'd9);
    issue(beq, 1'b0);
    sb.push_back(exp_of(beq));
    issue(lw8b, 1'b1);
    issue(add8b, 1'b0);
    chk("sf_stall_masked", 32'(pif.stall), 0);
    chk("sf_flush", 32'(pif.flush_ifid), 1);
    issue(nop(), 1'b0);
    chk("sf_ex_bubble", ex_out(), 0);
    chk("sf_mem_bubble", 32'({pif.mem_MRead, pif.mem_MWrite}), 0);
    drain(3);

    // Asynchronous reset with three instructions in flight
    r13 = mk(OP_RTYPE, 5'd1, 5'd2, 5'd13);
    r14 = mk(OP_RTYPE, 5'd1, 5'd2, 5'd14);
    r15 = mk(OP_RTYPE, 5'd1, 5'd2, 5'd15);
    issue(r13, 1'b0);
    issue(r14, 1'b0);
    issue(r15, 1'b0);
    chk("rst_pre_ex", 32'(pif.ex_RegDs), 1);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_cycle", all_out(), 0);
    drive(nop(), 1'b0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(nop(), 1'b0);
      chk("rst_no_wb", 32'(pif.wb_Urw), 0);
    end
    r16 = mk(OP_RTYPE, 5'd1, 5'd2, 5'd16);
    issue(r16, 1'b0);
    sb.push_back(exp_of(r16));
    issue(nop(), 1'b0);
    issue(nop(), 1'b0);
    chk("rst_new_wb_pending", 32'(pif.wb_Urw), 0);
    issue(nop(), 1'b0);
    chk("rst_new_wb_urw", 32'(pif.wb_Urw), 1);
    chk("rst_new_wb_wreg", 32'(pif.wb_wreg), 16);
    drain(3);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
